// File: rtl/pipe_stage_regs_if.sv
// pipe_stage_regs_if: hazard-facing signal bundle between pipeline control and the stage register bank
interface pipe_stage_regs_if #(parameter int CNT_W = 32);
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      IF_instr_i;
  logic [31:0]      IF_pc_i;
  logic             IF_valid_i;
  logic [4:0]       ID_rd_addr_i;
  logic             ID_rd_wr_en_i;
  logic [1:0]       ID_rd_src_i;
  logic [31:0]      ID_instr_o;
  logic [31:0]      ID_pc_o;
  logic             ID_valid_o;
  logic             pc_hold_o;
  logic [4:0]       EX_rd_addr_o;
  logic             EX_rd_wr_en_o;
  logic [1:0]       EX_rd_src_o;
  logic [4:0]       MEM_rd_addr_o;
  logic             MEM_rd_wr_en_o;
  logic             MEM_rd_src_o;
  logic [4:0]       WB_rd_addr_o;
  logic             WB_rd_wr_en_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] retire_cnt_o;
  modport master (
    output stall_i, flush_i, IF_instr_i, IF_pc_i, IF_valid_i,
           ID_rd_addr_i, ID_rd_wr_en_i, ID_rd_src_i,
    input  ID_instr_o, ID_pc_o, ID_valid_o, pc_hold_o,
           EX_rd_addr_o, EX_rd_wr_en_o, EX_rd_src_o,
           MEM_rd_addr_o, MEM_rd_wr_en_o, MEM_rd_src_o,
           WB_rd_addr_o, WB_rd_wr_en_o,
           stall_cnt_o, flush_cnt_o, retire_cnt_o
  );
  modport slave (
    input  stall_i, flush_i, IF_instr_i, IF_pc_i, IF_valid_i,
           ID_rd_addr_i, ID_rd_wr_en_i, ID_rd_src_i,
    output ID_instr_o, ID_pc_o, ID_valid_o, pc_hold_o,
           EX_rd_addr_o, EX_rd_wr_en_o, EX_rd_src_o,
           MEM_rd_addr_o, MEM_rd_wr_en_o, MEM_rd_src_o,
           WB_rd_addr_o, WB_rd_wr_en_o,
           stall_cnt_o, flush_cnt_o, retire_cnt_o
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: IF/ID..MEM/WB hazard-state registers with stall/flush handling and saturating event counters
module pipe_stage_regs #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_stage_regs_if.slave bus
);
  // rd source encoding shared with the decoder: 1 selects load data
  localparam logic [1:0]       RD_SOURCE_MEM = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  logic [31:0]      r_id_instr;
  logic [31:0]      r_id_pc;
  logic             r_id_valid;
  logic             r_ex_valid;
  logic [4:0]       r_ex_rd_addr;
  logic             r_ex_wr_en;
  logic [1:0]       r_ex_rd_src;
  logic             r_mem_valid;
  logic [4:0]       r_mem_rd_addr;
  logic             r_mem_wr_en;
  logic             r_mem_load;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd_addr;
  logic             r_wb_wr_en;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_squash;
  logic             w_ex_wr_en;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic e);
    return (e && c != CNT_MAX) ? c + 1'b1 : c;
  endfunction
  assign w_squash   = bus.flush_i | ~bus.IF_valid_i;
  assign w_ex_wr_en = bus.ID_rd_wr_en_i & |bus.ID_rd_addr_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= '0;
      r_id_valid    <= 1'b0;
      r_ex_valid    <= 1'b0;
      r_ex_rd_addr  <= '0;
      r_ex_wr_en    <= 1'b0;
      r_ex_rd_src   <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_load    <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_rd_addr  <= '0;
      r_wb_wr_en    <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_retire_cnt  <= '0;
    end else begin
      // stall outranks flush: the branch in ID is re-resolved next cycle
      if (!bus.stall_i) begin
        r_id_instr <= w_squash ? NOP_INSTR : bus.IF_instr_i;
        r_id_pc    <= bus.IF_pc_i;
        r_id_valid <= ~w_squash;
      end
      r_ex_valid    <= ~bus.stall_i & r_id_valid;
      r_ex_rd_addr  <= bus.stall_i ? 5'd0 : bus.ID_rd_addr_i;
      r_ex_wr_en    <= ~bus.stall_i & w_ex_wr_en;
      r_ex_rd_src   <= bus.stall_i ? 2'd0 : bus.ID_rd_src_i;
      r_mem_valid   <= r_ex_valid;
      r_mem_rd_addr <= r_ex_rd_addr;
      r_mem_wr_en   <= r_ex_wr_en;
      r_mem_load    <= r_ex_rd_src == RD_SOURCE_MEM;
      r_wb_valid    <= r_mem_valid;
      r_wb_rd_addr  <= r_mem_rd_addr;
      r_wb_wr_en    <= r_mem_wr_en;
      r_stall_cnt   <= sat_inc(r_stall_cnt, bus.stall_i);
      r_flush_cnt   <= sat_inc(r_flush_cnt, bus.flush_i & ~bus.stall_i);
      r_retire_cnt  <= sat_inc(r_retire_cnt, r_wb_valid);
    end
  end
  assign bus.ID_instr_o     = r_id_instr;
  assign bus.ID_pc_o        = r_id_pc;
  assign bus.ID_valid_o     = r_id_valid;
  assign bus.pc_hold_o      = bus.stall_i & ~rst_i;
  assign bus.EX_rd_addr_o   = r_ex_rd_addr;
  assign bus.EX_rd_wr_en_o  = r_ex_wr_en & r_ex_valid;
  assign bus.EX_rd_src_o    = r_ex_rd_src;
  assign bus.MEM_rd_addr_o  = r_mem_rd_addr;
  assign bus.MEM_rd_wr_en_o = r_mem_wr_en & r_mem_valid;
  assign bus.MEM_rd_src_o   = r_mem_load;
  assign bus.WB_rd_addr_o   = r_wb_rd_addr;
  assign bus.WB_rd_wr_en_o  = r_wb_wr_en & r_wb_valid;
  assign bus.stall_cnt_o    = r_stall_cnt;
  assign bus.flush_cnt_o    = r_flush_cnt;
  assign bus.retire_cnt_o   = r_retire_cnt;
endmodule
